uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

UART receiver with 16x oversampling; the counterpart to the team's UART transmitter on the same serial link. It samples the asynchronous `rx` line on the shared baud-rate `s_tick` strobe and assembles LSB-first frames into a parallel byte. Each completed frame produces a one-cycle done pulse plus framing and parity status. It feeds the MIPS debug/loader interface in the same way the transmitter is fed from it.

## Interface
- `DBIT`, 8, data bits per frame, legal range 5..8.
- `SB_TICK`, 16, number of `s_tick` periods spent in the stop bit: 16 for 1 stop bit, 24 for 1.5, 32 for 2.
- `clk` input 1: sole clock; all flops on the rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `rx` input 1: asynchronous serial line; idles high.
- `s_tick` input 1: one-`clk` strobe at 16x the baud rate.
- `dout` output 8: received data in `dout[DBIT-1:0]`; upper bits are 0.
- `rx_done_tick` output 1: one-`clk` pulse marking frame completion.
- `frame_err` output 1: the stop-bit sample of the last frame was 0.
- `parity_err` output 1: the parity check of the last frame failed.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rx_s`.
- State machine states: IDLE, START, DATA, PARITY, STOP. Counters: `s` (4-bit tick count), `n` (3-bit bit index), `b` (8-bit shift register).
- IDLE: when `rx_s` is 0, go to START with `s`=0. `s_tick` is not required to leave IDLE.
- START: on each `s_tick`, `s` increments. When `s`==7 (mid start bit):
  - if `rx_s`==0, go to DATA with `s`=0 and `n`=0;
  - otherwise this is a false start; return to IDLE and produce no pulse.
- DATA: on `s_tick` with `s`==15:
  - shift `b` = {`rx_s`, `b[7:1]`} and set `s`=0;
  - if `n`==DBIT-1, go to PARITY (macro defined) or STOP (macro not defined); else `n`++.
  - On any other `s_tick`, `s`++.
- PARITY: on `s_tick` with `s`==15, latch the parity result and go to STOP with `s`=0.
- STOP: on `s_tick` with `s`==SB_TICK-1:
  - sample `rx_s`;
  - update `dout` = `b >> (8-DBIT)`, set `frame_err` = !`rx_s`, update `parity_err`;
  - pulse `rx_done_tick`;
  - go to IDLE.
  - On any other `s_tick`, `s`++. `s` must hold the value 31, so `s` widens to 5 bits when SB_TICK>16.
- Frames with errors still deliver `dout` and still pulse `rx_done_tick`.
- `dout`, `frame_err` and `parity_err` hold their values until the next frame completes.
- A break condition (line held low) yields `dout`=0 and `frame_err`=1. The receiver then waits in IDLE until `rx_s` reads 1, so a held-low line is not re-detected as repeated start bits.

## Timing
- Reset values: state IDLE, all counters 0, `dout`=0x00, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0.
- Reset asserted mid-frame aborts the frame on the next clock edge, with no pulse and no output update.
- Latency from the `rx` falling edge: 2 `clk` for synchronization, then 8 + 16·DBIT (+16 with parity) + SB_TICK ticks until `rx_done_tick`.
- `dout` and the error flags are updated on the same edge that raises `rx_done_tick`, so they are valid during the pulse.
- There is no backpressure. A consumer must take `dout` before the next frame completes.
- Back-to-back frames are supported. The next start bit is detected in the first IDLE cycle.
- `s_tick` arriving in the same cycle as state entry is counted by the new state.

## Configuration
- `UART_RX_PARITY_EN`, when defined:
  - adds the PARITY state and an even-parity check over the DBIT data bits;
  - `parity_err` = received parity bit XOR reduction-XOR of the data bits.
- When not defined:
  - the PARITY state is absent;
  - DATA goes directly to STOP;
  - `parity_err` is tied to 0.
  - The port list is identical in both builds.

## Structure
- Shared package `uart_pkg` holds the state encodings (3-bit; PARITY is included even when unused), the tick constants 7/15, and the defaults for DBIT and SB_TICK. The transmitter uses the same package.
- One sub-module: `uart_sync2`, a 2-flop synchronizer with a reset value parameter, instantiated with reset value 1.

## Test plan
- Frame 0x55, DBIT=8, valid stop bit -> exactly one `rx_done_tick`, `dout`=0x55, `frame_err`=0.
- `rx` held low for only 4 ticks, then high -> no `rx_done_tick`, FSM back in IDLE, `dout` unchanged.
- Frame 0xA3 with stop bit 0 -> `dout`=0xA3, `frame_err`=1. A following clean 0x3C frame clears the flag to 0.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two pulses, `dout` 0x00 then 0xFF.
- Reset driven low mid-DATA on a 0x81 frame, then a clean 0x7E frame -> no pulse for the aborted frame, then `dout`=0x7E.
- With `UART_RX_PARITY_EN`: frame 0x0F with parity bit 1 -> `parity_err`=1; same frame with parity bit 0 -> `parity_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, tick constants, frame defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: uart_state_t (3-bit, PARITY always encoded), TICK_MID/TICK_LAST,
//           DBIT_DEF/SB_TICK_DEF. Shared by the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Tick index of the middle of the start bit, and last tick of a data bit.
  localparam int TICK_MID  = 7;
  localparam int TICK_LAST = 15;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with configurable reset value.
// Latency: 2 clk from i_d to o_q.
// Backpressure: none; samples every clock.
// Ports: i_clk (clock), i_reset_n (sync active-low reset), i_d (async input),
//        o_q (synchronized output).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver, 16x oversampled on s_tick, LSB-first, optional even parity.
// Latency: 2 clk sync + 8 + 16*DBIT (+16 parity) + SB_TICK ticks to rx_done_tick.
// Backpressure: none; dout/flags hold until the next frame completes.
// Ports: clk, reset (sync active-low), rx (async line, idles high), s_tick (16x baud
//        strobe), dout[7:0] (data in low DBIT bits), rx_done_tick (1-clk pulse),
//        frame_err (stop sample was 0), parity_err (parity check failed).
// Build option: define UART_RX_PARITY_EN to add the PARITY state and even-parity check;
//        otherwise parity_err is tied to 0. Ports are identical in both builds.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

  // 1.5 and 2 stop bits need the tick counter to reach 23 or 31.
  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(TICK_MID);
  localparam logic [SW-1:0] S_LAST = SW'(TICK_LAST);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
  localparam int            SHIFT  = 8 - DBIT;

  logic w_rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_d       (rx),
    .o_q       (w_rx_s)
  );

  uart_state_t   r_state, w_state;
  logic [SW-1:0] r_s, w_s;
  logic [2:0]    r_n, w_n;
  logic [7:0]    r_b, w_b;
  logic [7:0]    r_dout, w_dout;
  logic          r_done, w_done;
  logic          r_ferr, w_ferr;
  // Set after a frame ends on a low line (break); blocks start detection until rx_s is 1.
  logic          r_wait_high, w_wait_high;
  logic [7:0]    w_data;

  // Data bits enter at the top of b, so after DBIT shifts they sit in b[7:8-DBIT].
  assign w_data = r_b >> SHIFT;

`ifdef UART_RX_PARITY_EN
  logic r_par_res, w_par_res;
  logic r_perr, w_perr;
`endif

  always_comb begin
    w_state     = r_state;
    w_s         = r_s;
    w_n         = r_n;
    w_b         = r_b;
    w_dout      = r_dout;
    w_done      = 1'b0;
    w_ferr      = r_ferr;
    w_wait_high = r_wait_high;
`ifdef UART_RX_PARITY_EN
    w_par_res   = r_par_res;
    w_perr      = r_perr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_wait_high) begin
          if (w_rx_s) w_wait_high = 1'b0;
        end else if (!w_rx_s) begin
          w_state = ST_START;
          w_s     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            if (!w_rx_s) begin
              w_state = ST_DATA;
              w_s     = '0;
              w_n     = '0;
            end else begin
              w_state = ST_IDLE;  // glitch, not a start bit
            end
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_b = {w_rx_s, r_b[7:1]};
            w_s = '0;
            if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state = ST_PARITY;
`else
              w_state = ST_STOP;
`endif
            end else begin
              w_n = r_n + 1'b1;
            end
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_par_res = w_rx_s ^ (^w_data);
            w_state   = ST_STOP;
            w_s       = '0;
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP) begin
            w_dout      = w_data;
            w_ferr      = !w_rx_s;
            w_wait_high = !w_rx_s;
            w_done      = 1'b1;
            w_state     = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            w_perr      = r_par_res;
`endif
          end else begin
            w_s = r_s + 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_ferr      <= 1'b0;
      r_wait_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_res   <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_s         <= w_s;
      r_n         <= w_n;
      r_b         <= w_b;
      r_dout      <= w_dout;
      r_done      <= w_done;
      r_ferr      <= w_ferr;
      r_wait_high <= w_wait_high;
`ifdef UART_RX_PARITY_EN
      r_par_res   <= w_par_res;
      r_perr      <= w_perr;
`endif
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: serial frames driven bit by bit, outputs checked.
// Latency: s_tick every 4 clk, so one bit period is 64 clk.
// Backpressure: n/a.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic [7:0] cap_dout [0:1];

  uart_rx_frame dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Count done pulses and remember the last two delivered bytes.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      cap_dout[0] = cap_dout[1];
      cap_dout[1] = dout;
      n_done++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic v, input int ticks);
    @(negedge clk);
    rx = v;
    wait_ticks(ticks);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    send_data(d);
`ifdef UART_RX_PARITY_EN
    send_bit(^d, 16);
`endif
    send_bit(stop_v, 16);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_v);
    send_data(d);
    send_bit(par_v, 16);
    send_bit(1'b1, 16);
  endtask
`endif

  initial begin
    int base;
    reset = 1'b0;
    rx    = 1'b1;
    cap_dout[0] = 8'h00;
    cap_dout[1] = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_done", 32'(rx_done_tick), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    reset = 1'b1;
    send_bit(1'b1, 8);

    // Clean 0x55 frame.
    base = n_done;
    send_frame(8'h55, 1'b1);
    send_bit(1'b1, 8);
    chk("f55_pulses", 32'(n_done - base), 32'd1);
    chk("f55_dout", 32'(dout), 32'h55);
    chk("f55_ferr", 32'(frame_err), 32'd0);
    chk("f55_perr", 32'(parity_err), 32'd0);

    // False start: low for 4 ticks only.
    base = n_done;
    send_bit(1'b0, 4);
    send_bit(1'b1, 40);
    chk("false_pulses", 32'(n_done - base), 32'd0);
    chk("false_dout", 32'(dout), 32'h55);

    // Bad stop bit, then a clean frame clears the flag.
    base = n_done;
    send_frame(8'hA3, 1'b0);
    send_bit(1'b1, 8);
    chk("fa3_pulses", 32'(n_done - base), 32'd1);
    chk("fa3_dout", 32'(dout), 32'hA3);
    chk("fa3_ferr", 32'(frame_err), 32'd1);
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1, 8);
    chk("f3c_dout", 32'(dout), 32'h3C);
    chk("f3c_ferr", 32'(frame_err), 32'd0);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    base = n_done;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_bit(1'b1, 8);
    chk("b2b_pulses", 32'(n_done - base), 32'd2);
    chk("b2b_first", 32'(cap_dout[0]), 32'h00);
    chk("b2b_second", 32'(cap_dout[1]), 32'hFF);

    // Reset mid-DATA on 0x81, then clean 0x7E.
    base = n_done;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b0, 8);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_bit(1'b1, 40);
    chk("abort_pulses", 32'(n_done - base), 32'd0);
    chk("abort_dout", 32'(dout), 32'h00);
    send_frame(8'h7E, 1'b1);
    send_bit(1'b1, 8);
    chk("f7e_pulses", 32'(n_done - base), 32'd1);
    chk("f7e_dout", 32'(dout), 32'h7E);

    // Break: line held low well past one frame yields a single errored frame.
    base = n_done;
    send_bit(1'b0, 320);
    chk("brk_pulses", 32'(n_done - base), 32'd1);
    chk("brk_dout", 32'(dout), 32'h00);
    chk("brk_ferr", 32'(frame_err), 32'd1);
    send_bit(1'b1, 20);
    send_frame(8'h55, 1'b1);
    send_bit(1'b1, 8);
    chk("post_brk_dout", 32'(dout), 32'h55);
    chk("post_brk_ferr", 32'(frame_err), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame_par(8'h0F, 1'b1);
    send_bit(1'b1, 8);
    chk("par_bad_dout", 32'(dout), 32'h0F);
    chk("par_bad_perr", 32'(parity_err), 32'd1);
    send_frame_par(8'h0F, 1'b0);
    send_bit(1'b1, 8);
    chk("par_ok_perr", 32'(parity_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
